// File: rtl/pipe_ctrl_fsm_pkg.sv
// Shared constants, state encoding and target decode
// for the pipeline controller.
package pipe_ctrl_fsm_pkg;

  localparam int STALL_W = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_PC   = 6'b000001;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_RI      = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  typedef enum logic {
    RUN     = 1'b0,
    WAIT_IF = 1'b1
  } ctrl_state_e;

  // eret returns to EPC; everything else enters the vector
  function automatic logic [31:0] decode_tgt(
    input logic [31:0] exc,
    input logic [31:0] epc,
    input logic [31:0] vec
  );
    return (exc == EXC_ERET) ? epc : vec;
  endfunction

endpackage

// File: rtl/pipe_ctrl_fsm_perf_cnt.sv
// Saturating stall-cycle and flush counters.
// Only built when PIPE_CTRL_PERF_CNT_EN is defined.
`ifdef PIPE_CTRL_PERF_CNT_EN
module pipe_ctrl_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_any,
  input  logic        flush,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
);

  // count qualifying cycles, hold at all-ones
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (stall_any && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush && perf_flush_count != '1)
        perf_flush_count <= perf_flush_count + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/pipe_ctrl_fsm.sv
// Pipeline stall/flush/redirect controller.
// Perf counters enabled by PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl_fsm
  import pipe_ctrl_fsm_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic [31:0]        excepttype_i,
  input  logic [31:0]        cp0_epc_i,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               pc_redirect,
  output logic [31:0]        new_pc,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_flush_count
);

  ctrl_state_e state_q, state_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] dec_tgt;

  assign dec_tgt = decode_tgt(excepttype_i, cp0_epc_i, EXC_VECTOR);

  // state and latched redirect target
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  // next state and outputs; everything quiet in reset
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    stall       = STALL_NONE;
    flush       = 1'b0;
    pc_redirect = 1'b0;
    new_pc      = '0;
    if (rst) begin
      case (state_q)
        RUN: begin
          if (excepttype_i != EXC_NONE) begin
            flush = 1'b1;
            if (!stallreq_if) begin
              pc_redirect = 1'b1;
              new_pc      = dec_tgt;
            end else begin
              stall   = STALL_PC;
              tgt_d   = dec_tgt;
              state_d = WAIT_IF;
            end
          end else if (stallreq_mem) begin
            stall = STALL_MEM;
          end else if (stallreq_ex) begin
            stall = STALL_EX;
          end else if (stallreq_id) begin
            stall = STALL_ID;
          end else if (stallreq_if) begin
            stall = STALL_IF;
          end
        end
        WAIT_IF: begin
          if (stallreq_if) begin
            stall = STALL_PC;
          end else begin
            flush       = 1'b1;
            pc_redirect = 1'b1;
            new_pc      = tgt_q;
            state_d     = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  pipe_ctrl_perf_cnt u_perf (
    .clk               (clk),
    .rst               (rst),
    .stall_any         (stall != STALL_NONE),
    .flush             (flush),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
  );
`else
  assign perf_stall_cycles = 32'h0;
  assign perf_flush_count  = 32'h0;
`endif

endmodule
